gowin_alu54_sdpb_dn: RTL and testbench



---
 rtl/gowin_alu54_sdpb_dn.sv | 112 +++++++++++
 tb/tb_gowin_alu54_sdpb_dn.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/gowin_alu54_sdpb_dn.sv
// gowin_alu54_sdpb_dn
// Registered 21+5-bit address adder (22-bit sum, 55-bit cascade copy) plus an
// 8x32-bit write / 16x16-bit read simple dual-port burst cache.
// Optional feature macro: SDPB_PIPELINE_EN adds an oce-gated output register
// after the cache read register (2-cycle read latency instead of 1).
module gowin_alu54_sdpb_dn (
   input  logic        clk,
   input  logic        reset,
   input  logic [20:0] a,
   input  logic [4:0]  b,
   input  logic        ce,
   output logic [21:0] alu_dout,
   output logic [54:0] caso,
   input  logic        cea,
   input  logic [2:0]  ada,
   input  logic [31:0] din,
   input  logic        ceb,
   input  logic [3:0]  adb,
   input  logic        oce,
   output logic [15:0] sdpb_dout
);

   // Unsigned zero-extended add; 22 bits cannot overflow for 21+5-bit operands.
   function automatic logic [21:0] add_zext(input logic [20:0] op_a, input logic [4:0] op_b);
      return {1'b0, op_a} + {17'd0, op_b};
   endfunction

   // Select one pixel from a stored word: low half for even addresses.
   function automatic logic [15:0] pick_half(input logic [31:0] word, input logic hi);
      return hi ? word[31:16] : word[15:0];
   endfunction

   logic [21:0] sum_d, sum_q;
   logic [54:0] caso_d, caso_q;
   logic [31:0] mem_q [0:7];
   logic [31:0] rd_word;
   logic [15:0] rd_d, rd_q;

   // Adder next-state: load the new sum on ce, otherwise hold.
   always_comb begin
      sum_d  = sum_q;
      caso_d = caso_q;
      if (ce) begin
         sum_d  = add_zext(a, b);
         caso_d = {33'd0, add_zext(a, b)};
      end
   end

   // Adder output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_q  <= '0;
         caso_q <= '0;
      end else begin
         sum_q  <= sum_d;
         caso_q <= caso_d;
      end
   end

   // Cache storage: never reset, so a burst survives a reset pulse.
   always_ff @(posedge clk) begin
      if (cea)
         mem_q[ada] <= din;
   end

   // Read next-state: the array is sampled before this edge's write lands,
   // giving read-before-write on a same-word collision.
   always_comb begin
      rd_word = mem_q[adb[3:1]];
      rd_d    = rd_q;
      if (ceb)
         rd_d = pick_half(rd_word, adb[0]);
   end

   // Cache read register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rd_q <= '0;
      else
         rd_q <= rd_d;
   end

`ifdef SDPB_PIPELINE_EN
   logic [15:0] out_d, out_q;

   // Output-register next-state: advance the read data only on oce.
   always_comb begin
      out_d = out_q;
      if (oce)
         out_d = rd_q;
   end

   // Second read pipeline register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         out_q <= '0;
      else
         out_q <= out_d;
   end

   assign sdpb_dout = out_q;
`else
   // Bypass build: oce has no function.
   logic unused_oce;
   assign unused_oce = oce;
   assign sdpb_dout  = rd_q;
`endif

   assign alu_dout = sum_q;
   assign caso     = caso_q;

endmodule

// File: tb/tb_gowin_alu54_sdpb_dn.sv
// Directed self-checking bench for gowin_alu54_sdpb_dn (both build variants).
module tb_gowin_alu54_sdpb_dn;

   logic        clk = 1'b0;
   logic        reset;
   logic [20:0] a;
   logic [4:0]  b;
   logic        ce;
   logic [21:0] alu_dout;
   logic [54:0] caso;
   logic        cea;
   logic [2:0]  ada;
   logic [31:0] din;
   logic        ceb;
   logic [3:0]  adb;
   logic        oce;
   logic [15:0] sdpb_dout;

   int chk_cnt = 0;
   int err_cnt = 0;

   gowin_alu54_sdpb_dn dut (
      .clk(clk), .reset(reset),
      .a(a), .b(b), .ce(ce), .alu_dout(alu_dout), .caso(caso),
      .cea(cea), .ada(ada), .din(din),
      .ceb(ceb), .adb(adb), .oce(oce), .sdpb_dout(sdpb_dout)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; a = '0; b = '0; ce = 1'b0;
      cea = 1'b0; ada = '0; din = '0; ceb = 1'b0; adb = '0; oce = 1'b1;
      tick();
      chk("rst_alu",  64'(alu_dout),  64'h0);
      chk("rst_caso", 64'(caso),      64'h0);
      chk("rst_sdpb", 64'(sdpb_dout), 64'h0);
      reset = 1'b0;
      tick();
      chk("post_rst_alu",  64'(alu_dout),  64'h0);
      chk("post_rst_sdpb", 64'(sdpb_dout), 64'h0);

      // Adder: maximal operands
      a = 21'h1FFFFF; b = 5'd31; ce = 1'b1;
      tick();
      chk("add_max_alu",  64'(alu_dout), 64'h20001E);
      chk("add_max_caso", 64'(caso),     64'h20001E);
      ce = 1'b0; a = 21'h000005; b = 5'd1;
      tick();
      chk("add_hold_alu",  64'(alu_dout), 64'h20001E);
      chk("add_hold_caso", 64'(caso),     64'h20001E);
      a = 21'h012345; b = 5'd7; ce = 1'b1;
      tick();
      chk("add_mid_alu", 64'(alu_dout), 64'h01234C);
      ce = 1'b0;

      // Burst fill: word k = {2k+1, 2k}
      for (int k = 0; k < 8; k++) begin
         cea = 1'b1; ada = 3'(k);
         din = {16'(2*k + 1), 16'(2*k)};
         tick();
      end
      cea = 1'b0;

      // Burst replay
      for (int i = 0; i < 16; i++) begin
         ceb = 1'b1; adb = 4'(i);
         tick();
`ifdef SDPB_PIPELINE_EN
         if (i > 0) chk($sformatf("replay_%0d", i - 1), 64'(sdpb_dout), 64'(i - 1));
`else
         chk($sformatf("replay_%0d", i), 64'(sdpb_dout), 64'(i));
`endif
      end
      ceb = 1'b0;
      tick();
      chk("replay_tail", 64'(sdpb_dout), 64'd15);

      // Read hold
      ceb = 1'b1; adb = 4'd5;
      tick();
      ceb = 1'b0; adb = 4'd9;
      tick();
      chk("hold_a", 64'(sdpb_dout), 64'd5);
      adb = 4'd12;
      tick();
      chk("hold_b", 64'(sdpb_dout), 64'd5);

      // Collision: read-before-write
      cea = 1'b1; ada = 3'd3; din = 32'hBBBB_AAAA;
      tick();
      din = 32'h2222_1111; ceb = 1'b1; adb = 4'd6;
      tick();
      cea = 1'b0; ceb = 1'b0;
`ifndef SDPB_PIPELINE_EN
      chk("collide_old_now", 64'(sdpb_dout), 64'hAAAA);
`endif
      tick();
      chk("collide_old", 64'(sdpb_dout), 64'hAAAA);
      ceb = 1'b1; adb = 4'd6;
      tick();
      ceb = 1'b0;
      tick();
      chk("collide_new", 64'(sdpb_dout), 64'h1111);

      // oce gating (pipeline) / oce ignored (bypass)
      oce = 1'b0; ceb = 1'b1; adb = 4'd1;
      tick();
      ceb = 1'b0;
`ifdef SDPB_PIPELINE_EN
      chk("oce_off_a", 64'(sdpb_dout), 64'h1111);
      tick();
      chk("oce_off_b", 64'(sdpb_dout), 64'h1111);
`else
      chk("oce_ignored", 64'(sdpb_dout), 64'd1);
      tick();
`endif
      oce = 1'b1;
      tick();
      chk("oce_on", 64'(sdpb_dout), 64'd1);

      // Asynchronous reset mid-run, no clock edge
      reset = 1'b1;
      #1;
      chk("async_rst_alu",  64'(alu_dout),  64'h0);
      chk("async_rst_caso", 64'(caso),      64'h0);
      chk("async_rst_sdpb", 64'(sdpb_dout), 64'h0);
      tick();
      reset = 1'b0;
      tick();
      chk("rst_stay_alu",  64'(alu_dout),  64'h0);
      chk("rst_stay_sdpb", 64'(sdpb_dout), 64'h0);

      // Memory survives reset; adder resumes
      ceb = 1'b1; adb = 4'd7; ce = 1'b1; a = 21'd10; b = 5'd5;
      tick();
      ceb = 1'b0; ce = 1'b0;
      chk("resume_alu",  64'(alu_dout), 64'd15);
      chk("resume_caso", 64'(caso),     64'd15);
      tick();
      chk("mem_kept", 64'(sdpb_dout), 64'h2222);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
